// File: rtl/dshot_pkg.sv
// Shared DSHOT definitions: frame width, command range, scheduler states and CRC nibble.
// The bidirectional CRC variant is selected in dshot_crc via DSHOT_BIDIR_EN.
package dshot_pkg;

   localparam int DSHOT_FRAME_W = 16;
   localparam int DSHOT_CMD_MIN = 1;
   localparam int DSHOT_CMD_MAX = 47;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_BUILD      = 3'd1,
      ST_WAIT_READY = 3'd2,
      ST_WRITE      = 3'd3,
      ST_HOLD       = 3'd4
   } dshot_state_e;

   function automatic logic [3:0] dshot_crc4(input logic [11:0] v);
      return v[3:0] ^ v[7:4] ^ v[11:8];
   endfunction

   function automatic logic dshot_is_cmd(input logic [10:0] thr);
      return (thr >= 11'(DSHOT_CMD_MIN)) && (thr <= 11'(DSHOT_CMD_MAX));
   endfunction

endpackage

// File: rtl/dshot_crc.sv
// Combinational DSHOT CRC nibble over the 12-bit {throttle, telem} word.
// Defining DSHOT_BIDIR_EN inverts the nibble for bidirectional DSHOT.
module dshot_crc
   import dshot_pkg::*;
(
   input  logic [11:0] value_i,
   output logic [3:0]  crc_o
);

`ifdef DSHOT_BIDIR_EN
   assign crc_o = ~dshot_crc4(value_i);
`else
   assign crc_o = dshot_crc4(value_i);
`endif

endmodule

// File: rtl/dshot_frame_scheduler.sv
// Builds DSHOT frames from the staged request and writes them to dshot_output once per refresh tick.
// CRC polarity follows DSHOT_BIDIR_EN (see dshot_crc).
//
// state         | meaning
// ST_IDLE       | waiting for a refresh tick; ticks seen while disabled are dropped
// ST_BUILD      | latch frame from the stage into o_dshot_value
// ST_WAIT_READY | wait for downstream ready; disable aborts without writing
// ST_WRITE      | one-cycle o_write strobe
// ST_HOLD       | wait for downstream ready to drop, bounded by HOLD_TIMEOUT
module dshot_frame_scheduler
   import dshot_pkg::*;
#(
   parameter int clockFrequency = 72_000_000,
   parameter int REFRESH_HZ     = 1000,
   parameter int CMD_REPEAT     = 10,
   parameter int HOLD_TIMEOUT   = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [10:0]              i_throttle,
   input  logic                     i_telem,
   input  logic                     i_update,
   input  logic                     i_enable,
   output logic [DSHOT_FRAME_W-1:0] o_dshot_value,
   output logic                     o_write,
   input  logic                     i_ready,
   output logic                     o_busy,
   output logic                     o_cmd_active,
   output logic                     o_overrun,
   output logic                     o_timeout
);

   localparam int REFRESH_TICKS = clockFrequency / REFRESH_HZ;
   localparam int TIMER_W       = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
   localparam int HOLD_W        = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
   localparam logic [7:0] REPEAT_INIT = 8'(CMD_REPEAT);

   dshot_state_e state_q, state_d;

   logic [TIMER_W-1:0]       timer_q, timer_d;
   logic                     tick_pend_q, tick_pend_d;
   logic                     overrun_q, overrun_d;
   logic                     timeout_q, timeout_d;
   logic [HOLD_W-1:0]        hold_q, hold_d;
   logic [DSHOT_FRAME_W-1:0] value_q, value_d;
   logic                     frame_cmd_q, frame_cmd_d;
   logic [10:0]              stage_thr_q, stage_thr_d;
   logic                     stage_tel_q, stage_tel_d;
   logic                     cmd_act_q, cmd_act_d;
   logic [7:0]               rep_q, rep_d;
   logic                     pend_v_q, pend_v_d;
   logic [10:0]              pend_thr_q, pend_thr_d;
   logic                     pend_tel_q, pend_tel_d;

   logic        wrap, tick_clr, cmd_wr, stage_is_cmd;
   logic        ld, ld_tel;
   logic [10:0] ld_thr;
   logic [11:0] frame_word;
   logic [3:0]  frame_crc;

   assign stage_is_cmd = dshot_is_cmd(stage_thr_q);
   assign frame_word   = {stage_thr_q, stage_is_cmd | stage_tel_q};

   dshot_crc u_crc (
      .value_i (frame_word),
      .crc_o   (frame_crc)
   );

   assign wrap        = (timer_q == TIMER_W'(REFRESH_TICKS - 1));
   assign timer_d     = wrap ? '0 : timer_q + 1'b1;
   assign tick_pend_d = wrap | (tick_pend_q & ~tick_clr);
   assign overrun_d   = overrun_q | (wrap & tick_pend_q);

   always_comb begin
      state_d     = state_q;
      tick_clr    = 1'b0;
      value_d     = value_q;
      frame_cmd_d = frame_cmd_q;
      hold_d      = hold_q;
      timeout_d   = timeout_q;
      o_write     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick_pend_q) begin
               tick_clr = 1'b1;
               if (i_enable) state_d = ST_BUILD;
            end
         end
         ST_BUILD: begin
            value_d     = {frame_word, frame_crc};
            frame_cmd_d = stage_is_cmd;
            state_d     = ST_WAIT_READY;
         end
         ST_WAIT_READY: begin
            if (!i_enable)    state_d = ST_IDLE;
            else if (i_ready) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            // The outgoing frame serves any tick that piled up while stalled.
            o_write  = 1'b1;
            tick_clr = 1'b1;
            hold_d   = HOLD_W'(HOLD_TIMEOUT - 1);
            state_d  = ST_HOLD;
         end
         ST_HOLD: begin
            if (!i_ready) begin
               state_d = ST_IDLE;
            end else if (hold_q == '0) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Only frames built from a command count against the repeat budget.
   assign cmd_wr = (state_q == ST_WRITE) && cmd_act_q && frame_cmd_q;

   always_comb begin
      stage_thr_d = stage_thr_q;
      stage_tel_d = stage_tel_q;
      cmd_act_d   = cmd_act_q;
      rep_d       = rep_q;
      pend_v_d    = pend_v_q;
      pend_thr_d  = pend_thr_q;
      pend_tel_d  = pend_tel_q;
      ld          = 1'b0;
      ld_thr      = i_throttle;
      ld_tel      = i_telem;
      if (cmd_wr) rep_d = rep_q - 8'd1;
      if (cmd_wr && rep_q <= 8'd1) begin
         ld       = 1'b1;
         pend_v_d = 1'b0;
         if (!i_update) begin
            ld_thr = pend_v_q ? pend_thr_q : '0;
            ld_tel = pend_v_q ? pend_tel_q : 1'b0;
         end
      end else if (i_update) begin
         if (cmd_act_q) begin
            pend_v_d   = 1'b1;
            pend_thr_d = i_throttle;
            pend_tel_d = i_telem;
         end else begin
            ld = 1'b1;
         end
      end
      if (ld) begin
         stage_thr_d = ld_thr;
         stage_tel_d = ld_tel;
         cmd_act_d   = dshot_is_cmd(ld_thr);
         if (dshot_is_cmd(ld_thr)) rep_d = REPEAT_INIT;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         tick_pend_q <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         hold_q      <= '0;
         value_q     <= '0;
         frame_cmd_q <= 1'b0;
         stage_thr_q <= '0;
         stage_tel_q <= 1'b0;
         cmd_act_q   <= 1'b0;
         rep_q       <= '0;
         pend_v_q    <= 1'b0;
         pend_thr_q  <= '0;
         pend_tel_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         tick_pend_q <= tick_pend_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         hold_q      <= hold_d;
         value_q     <= value_d;
         frame_cmd_q <= frame_cmd_d;
         stage_thr_q <= stage_thr_d;
         stage_tel_q <= stage_tel_d;
         cmd_act_q   <= cmd_act_d;
         rep_q       <= rep_d;
         pend_v_q    <= pend_v_d;
         pend_thr_q  <= pend_thr_d;
         pend_tel_q  <= pend_tel_d;
      end
   end

   assign o_dshot_value = value_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_cmd_active  = cmd_act_q;
   assign o_overrun     = overrun_q;
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_dshot_frame_scheduler.sv
// Scoreboard bench for dshot_frame_scheduler: a frame-level request model predicts every write.
// Honours DSHOT_BIDIR_EN for the expected CRC nibble.
module tb_dshot_frame_scheduler;

   localparam int T       = 20;
   localparam int CMD_REP = 10;
   localparam int HOLD_TO = 8;

`ifdef DSHOT_BIDIR_EN
   localparam logic [15:0] F_1000 = 16'h7D05;
   localparam logic [15:0] F_48   = 16'h0609;
   localparam logic [15:0] F_0    = 16'h000F;
   localparam logic [15:0] F_CMD1 = 16'h003C;
`else
   localparam logic [15:0] F_1000 = 16'h7D0A;
   localparam logic [15:0] F_48   = 16'h0606;
   localparam logic [15:0] F_0    = 16'h0000;
   localparam logic [15:0] F_CMD1 = 16'h0033;
`endif

   logic        i_clk, i_reset, i_telem, i_update, i_enable, i_ready;
   logic [10:0] i_throttle;
   logic [15:0] o_dshot_value;
   logic        o_write, o_busy, o_cmd_active, o_overrun, o_timeout;

   dshot_frame_scheduler #(
      .clockFrequency (2000),
      .REFRESH_HZ     (100),
      .CMD_REPEAT     (CMD_REP),
      .HOLD_TIMEOUT   (HOLD_TO)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_throttle    (i_throttle),
      .i_telem       (i_telem),
      .i_update      (i_update),
      .i_enable      (i_enable),
      .o_dshot_value (o_dshot_value),
      .o_write       (o_write),
      .i_ready       (i_ready),
      .o_busy        (o_busy),
      .o_cmd_active  (o_cmd_active),
      .o_overrun     (o_overrun),
      .o_timeout     (o_timeout)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int tests = 0, fails = 0;
   int cyc = 0, rst_cyc = 0, wr_cnt = 0, last_wr = -1, drop = 0;
   bit per_chk = 0, ds_low = 0, ds_stuck = 0;
   logic [16:0] exp_q[$];
   logic [16:0] mon_e;

   // reference model: staged request, remaining command frames, pending slot
   int m_thr, m_tel, m_rem, m_pv, m_pthr, m_ptel;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input int thr, input int tel);
      int v, c;
      v = thr * 2 + tel;
      c = (v ^ (v >> 4) ^ (v >> 8)) % 16;
`ifdef DSHOT_BIDIR_EN
      c = 15 - c;
`endif
      return 16'(v * 16 + c);
   endfunction

   function automatic bit is_cmd(input int thr);
      return thr >= 1 && thr <= 47;
   endfunction

   task automatic m_set(input int thr, input int tel);
      m_thr = thr;
      m_tel = tel;
      m_rem = is_cmd(thr) ? CMD_REP : 0;
   endtask

   task automatic m_update(input int thr, input int tel);
      if (m_rem > 0) begin
         m_pv = 1; m_pthr = thr; m_ptel = tel;
      end else begin
         m_set(thr, tel);
      end
   endtask

   task automatic m_next(output logic [16:0] e);
      e = {m_rem > 0, enc(m_thr, is_cmd(m_thr) ? 1 : m_tel)};
      if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            if (m_pv != 0) m_set(m_pthr, m_ptel);
            else m_set(0, 0);
            m_pv = 0;
         end
      end
   endtask

   task automatic push_model();
      logic [16:0] e;
      m_next(e);
      exp_q.push_back(e);
   endtask

   task automatic push_lit(input logic [15:0] f, input logic c);
      logic [16:0] e;
      m_next(e);
      exp_q.push_back({c, f});
   endtask

   function automatic int phase();
      return (cyc - rst_cyc) % T;
   endfunction

   task automatic do_reset();
      i_reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      rst_cyc = cyc;
      i_reset = 1'b0;
      m_set(0, 0);
      m_pv = 0;
      exp_q.delete();
      last_wr = -1;
   endtask

   task automatic issue(input int thr, input int tel);
      @(negedge i_clk);
      i_throttle = 11'(thr);
      i_telem    = 1'(tel);
      i_update   = 1'b1;
      @(negedge i_clk);
      i_update   = 1'b0;
      m_update(thr, tel);
   endtask

   task automatic wait_write(input int settle);
      int old;
      bit seen;
      old  = wr_cnt;
      seen = 0;
      for (int i = 0; i < 3 * T && !seen; i++) begin
         @(negedge i_clk);
         #1;
         seen = (wr_cnt != old);
      end
      chk("write_seen", 32'(seen), 32'd1);
      repeat (settle) @(negedge i_clk);
   endtask

   initial begin
      forever begin
         @(posedge i_clk);
         cyc++;
      end
   end

   // downstream stand-in: ready drops for 4 cycles after each write
   initial begin
      i_ready = 1'b1;
      forever begin
         @(negedge i_clk);
         if (ds_low) begin
            i_ready = 1'b0;
            drop = 0;
         end else if (o_write === 1'b1 && !ds_stuck) begin
            i_ready = 1'b0;
            drop = 4;
         end else if (drop > 0) begin
            drop--;
            if (drop == 0) i_ready = 1'b1;
         end else begin
            i_ready = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge i_clk);
         if (i_reset === 1'b0 && o_write === 1'b1) begin
            wr_cnt++;
            if (per_chk && last_wr >= 0) chk("write_period", 32'(cyc - last_wr), 32'(T));
            last_wr = cyc;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got 0x%0h with no frame expected", o_dshot_value);
            end else begin
               mon_e = exp_q.pop_front();
               chk("frame", 32'(o_dshot_value), 32'(mon_e[15:0]));
               chk("cmd_active", 32'(o_cmd_active), 32'(mon_e[16]));
            end
         end
      end
   end

   initial begin
      int old, r, thr;
      i_reset = 1'b0; i_update = 1'b0; i_throttle = '0; i_telem = 1'b0; i_enable = 1'b1;
      do_reset();
      @(negedge i_clk);
      chk("rst_write", 32'(o_write), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_value", 32'(o_dshot_value), 0);
      chk("rst_cmd", 32'(o_cmd_active), 0);
      chk("rst_overrun", 32'(o_overrun), 0);
      chk("rst_timeout", 32'(o_timeout), 0);

      // directed frames
      per_chk = 1;
      issue(1000, 0); push_lit(F_1000, 1'b0); wait_write(8);
      issue(48, 0);   push_lit(F_48, 1'b0);   wait_write(8);
      issue(0, 0);    push_lit(F_0, 1'b0);    wait_write(8);
      issue(1, 0);
      for (int i = 0; i < CMD_REP; i++) begin
         if (i == 3) issue(1000, 0);
         push_lit(F_CMD1, 1'b1);
         wait_write(8);
      end
      push_lit(F_1000, 1'b0); wait_write(8);

      // randomized requests
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 9) < 4) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      thr = int'($urandom_range(1, 47));
            else if (r < 3) thr = 0;
            else            thr = int'($urandom_range(48, 2047));
            issue(thr, int'($urandom_range(0, 1)));
         end
         push_model();
         wait_write(8);
      end

      // downstream stalled across several ticks
      per_chk = 0;
      chk("overrun_clear", 32'(o_overrun), 0);
      ds_low = 1;
      repeat (3 * T) @(negedge i_clk);
      for (int i = 0; i < T && phase() != 2; i++) @(negedge i_clk);
      chk("busy_stalled", 32'(o_busy), 1);
      chk("overrun_set", 32'(o_overrun), 1);
      push_model();
      old = wr_cnt;
      ds_low = 0;
      repeat (12) @(negedge i_clk);
      chk("one_write_after_stall", 32'(wr_cnt - old), 1);

      // downstream never drops ready after a write
      chk("timeout_clear", 32'(o_timeout), 0);
      push_model();
      ds_stuck = 1;
      wait_write(0);
      repeat (HOLD_TO - 1) @(negedge i_clk);
      chk("timeout_early", 32'(o_timeout), 0);
      chk("busy_in_hold", 32'(o_busy), 1);
      repeat (3) @(negedge i_clk);
      chk("timeout_set", 32'(o_timeout), 1);
      chk("idle_after_timeout", 32'(o_busy), 0);
      ds_stuck = 0;

      // reset in the middle of a command write
      issue(9, 0);
      push_model();
      wait_write(0);
      chk("cmd_before_reset", 32'(o_cmd_active), 1);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("mid_rst_write", 32'(o_write), 0);
      chk("mid_rst_busy", 32'(o_busy), 0);
      chk("mid_rst_value", 32'(o_dshot_value), 0);
      chk("mid_rst_cmd", 32'(o_cmd_active), 0);
      chk("mid_rst_overrun", 32'(o_overrun), 0);
      chk("mid_rst_timeout", 32'(o_timeout), 0);
      do_reset();
      push_model();
      wait_write(8);

      // disabled: no frames at all
      i_enable = 1'b0;
      old = wr_cnt;
      repeat (4 * T) @(negedge i_clk);
      chk("disabled_writes", 32'(wr_cnt - old), 0);
      chk("disabled_busy", 32'(o_busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog expired");
   end

endmodule
